rsa_exp_sched: RTL

Two-requester scheduler that shares one modular-multiply datapath to compute base^exp mod n for the RSA decryption path. Typical requesters are the CRT half-exponentiations (mod p, mod q). Requests are accepted through round-robin arbitration. The block then sequences right-to-left square-and-multiply on an internal multi-cycle modular multiplier and returns the result with a requester tag over a valid/ready handshake. One job is in flight at a time.

---
 rtl/rsa_pkg.sv | 20 ++
 rtl/rsa_exp_sched_if.sv | 29 ++
 rtl/rsa_mod_mul.sv | 42 ++++
 rtl/rsa_exp_sched.sv | 138 +++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA modular-exponentiation scheduler.
package rsa_pkg;

  localparam int W          = 32;
  localparam int MODMUL_LAT = 2;
  localparam int CNT_W      = $clog2(W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL,
    S_MWAIT,
    S_SQR,
    S_SWAIT,
    S_DONE
  } state_t;

  typedef logic [0:0] req_id_t;

endpackage

// File: rtl/rsa_exp_sched_if.sv
// Request/response bundle between two requesters, one consumer and rsa_exp_sched.
interface rsa_exp_sched_if;
  import rsa_pkg::*;

  logic         req0_valid, req0_ready;
  logic [W-1:0] req0_base, req0_exp, req0_mod;
  logic         req1_valid, req1_ready;
  logic [W-1:0] req1_base, req1_exp, req1_mod;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_data;
  req_id_t      rsp_id;
  logic         rsp_err;
  logic         busy;

  modport master (
    output req0_valid, req0_base, req0_exp, req0_mod,
    output req1_valid, req1_base, req1_exp, req1_mod,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

  modport slave (
    input  req0_valid, req0_base, req0_exp, req0_mod,
    input  req1_valid, req1_base, req1_exp, req1_mod,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_data, rsp_id, rsp_err, busy
  );

endinterface

// File: rtl/rsa_mod_mul.sv
// Two-stage modular multiplier: stage 1 registers a*b, stage 2 registers the remainder mod n.
module rsa_mod_mul
  import rsa_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         op_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic         op_done,
  output logic [W-1:0] r
);

  logic [2*W-1:0] prod_q;
  logic [W-1:0]   n_q;
  logic [W-1:0]   r_q;
  logic           v1_q, v2_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      n_q    <= '0;
      r_q    <= '0;
    end else begin
      v1_q <= op_valid;
      v2_q <= v1_q;
      if (op_valid) begin
        prod_q <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
        n_q    <= n;
      end
      if (v1_q) r_q <= W'(prod_q % {{W{1'b0}}, n_q});
    end
  end

  assign op_done = v2_q;
  assign r       = r_q;

endmodule

// File: rtl/rsa_exp_sched.sv
// Round-robin two-requester scheduler running right-to-left square-and-multiply on rsa_mod_mul.
// Define RSA_CONST_TIME_EN for a data-independent schedule that scans all W exponent bits.
module rsa_exp_sched
  import rsa_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  rsa_exp_sched_if.slave bus
);

  state_t           state, state_nxt;
  logic [W-1:0]     base_r, exp_r, mod_r, res_r;
  logic [CNT_W-1:0] cnt_r;
  req_id_t          id_r, last_grant, grant;
  logic             err_r;
  logic             accept, loop_end;
  logic             op_valid, op_done;
  logic [W-1:0]     op_a, op_r, exp_shift;

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
    else if (bus.req1_valid)              grant = 1'b1;
  end

  assign accept    = (state == S_IDLE) && (bus.req0_valid || bus.req1_valid);
  assign exp_shift = exp_r >> 1;
`ifdef RSA_CONST_TIME_EN
  assign loop_end  = (cnt_r == CNT_W'(1));
`else
  assign loop_end  = (exp_shift == '0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept) state_nxt = S_LOAD;
      S_LOAD: begin
`ifdef RSA_CONST_TIME_EN
        state_nxt = (mod_r == '0) ? S_DONE : S_MUL;
`else
        if (mod_r == '0 || exp_r == '0) state_nxt = S_DONE;
        else                             state_nxt = exp_r[0] ? S_MUL : S_SQR;
`endif
      end
      S_MUL:   state_nxt = S_MWAIT;
      S_MWAIT: if (op_done) state_nxt = S_SQR;
      S_SQR:   state_nxt = S_SWAIT;
      S_SWAIT: begin
        if (op_done) begin
`ifdef RSA_CONST_TIME_EN
          state_nxt = loop_end ? S_DONE : S_MUL;
`else
          if (loop_end)          state_nxt = S_DONE;
          else if (exp_shift[0]) state_nxt = S_MUL;
          else                   state_nxt = S_SQR;
`endif
        end
      end
      S_DONE:  if (bus.rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req0_ready = (state == S_IDLE) && bus.req0_valid && (grant == 1'b0);
    bus.req1_ready = (state == S_IDLE) && bus.req1_valid && (grant == 1'b1);
    bus.busy       = (state != S_IDLE);
    bus.rsp_valid  = (state == S_DONE);
    bus.rsp_data   = (state == S_DONE) ? res_r : '0;
    bus.rsp_id     = (state == S_DONE) ? id_r  : 1'b0;
    bus.rsp_err    = (state == S_DONE) ? err_r : 1'b0;
    op_valid       = (state == S_MUL) || (state == S_SQR);
    op_a           = (state == S_MUL) ? res_r : base_r;
  end

  // NOTE: the job registers are reset so an aborted job leaves nothing visible on rsp_* afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r     <= '0;
      exp_r      <= '0;
      mod_r      <= '0;
      res_r      <= '0;
      cnt_r      <= '0;
      id_r       <= 1'b0;
      err_r      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          base_r     <= grant ? bus.req1_base : bus.req0_base;
          exp_r      <= grant ? bus.req1_exp  : bus.req0_exp;
          mod_r      <= grant ? bus.req1_mod  : bus.req0_mod;
          id_r       <= grant;
          last_grant <= grant;
          err_r      <= 1'b0;
        end
        S_LOAD: begin
          cnt_r <= CNT_W'(W);
          if (mod_r == '0) begin
            base_r <= '0;
            res_r  <= '0;
            err_r  <= 1'b1;
          end else begin
            base_r <= base_r % mod_r;
            res_r  <= W'(1) % mod_r;
          end
        end
        // In constant-time mode MUL runs for every bit; only a set bit keeps the product.
        S_MWAIT: if (op_done && exp_r[0]) res_r <= op_r;
        S_SWAIT: if (op_done) begin
          base_r <= op_r;
          exp_r  <= exp_shift;
          cnt_r  <= cnt_r - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  rsa_mod_mul u_mod_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .a        (op_a),
    .b        (base_r),
    .n        (mod_r),
    .op_done  (op_done),
    .r        (op_r)
  );

endmodule
